// File: rtl/hilo_muldiv_if.sv
// HI/LO unit command/result bundle.
// master: control unit side (drives op, A, B, cancel; observes hi, lo, busy, done)
// slave : hilo_muldiv side
//   op     [2:0]      command (none/MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   A, B   [width-1:0] rs / rt operands
//   cancel            abort an in-flight mul/div
//   hi, lo [width-1:0] architectural HI/LO registers
//   busy              mul/div in progress, commands ignored
//   done              one-cycle pulse when a mul/div result is committed
interface hilo_muldiv_if #(
  parameter int unsigned width = 32
);
  logic [2:0]       op;
  logic [width-1:0] A;
  logic [width-1:0] B;
  logic             cancel;
  logic [width-1:0] hi;
  logic [width-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output op, A, B, cancel,
    input  hi, lo, busy, done
  );

  modport slave (
    input  op, A, B, cancel,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Sequential HI/LO register unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU one bit
// per cycle (shift-add multiply, restoring divide) and services MTHI/MTLO.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hilo_muldiv_if.slave (op, A, B, cancel in; hi, lo, busy, done out)
// width must be even and at least 4.
module hilo_muldiv #(
  parameter int unsigned width = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hilo_muldiv_if.slave  bus
);

  localparam int unsigned cnt_w = $clog2(width);
  localparam int unsigned dw    = 2 * width;

  localparam logic [2:0] op_mult  = 3'b001;
  localparam logic [2:0] op_multu = 3'b010;
  localparam logic [2:0] op_div   = 3'b011;
  localparam logic [2:0] op_divu  = 3'b100;
  localparam logic [2:0] op_mthi  = 3'b101;
  localparam logic [2:0] op_mtlo  = 3'b110;

  localparam logic [1:0] s_idle   = 2'd0;
  localparam logic [1:0] s_calc   = 2'd1;
  localparam logic [1:0] s_commit = 2'd2;

  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(width - 1);

  logic [1:0]       state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [dw-1:0]    acc_q, acc_d;
  logic [width-1:0] mag_a_q, mag_a_d;
  logic [width-1:0] mag_b_q, mag_b_d;
  logic [width-1:0] a_q, a_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [width-1:0] hi_q, hi_d;
  logic [width-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand decode and magnitudes for the start edge
  logic             start_op;
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [width-1:0] abs_a;
  logic [width-1:0] abs_b;

  assign start_op  = (bus.op == op_mult) || (bus.op == op_multu) ||
                     (bus.op == op_div)  || (bus.op == op_divu);
  assign op_signed = (bus.op == op_mult) || (bus.op == op_div);
  assign a_neg     = op_signed & bus.A[width-1];
  assign b_neg     = op_signed & bus.B[width-1];
  assign abs_a     = a_neg ? (-bus.A) : bus.A;
  assign abs_b     = b_neg ? (-bus.B) : bus.B;

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  logic [width:0]   mul_sum;
  logic [dw-1:0]    mul_next;

  assign mul_sum  = {1'b0, acc_q[dw-1:width]} +
                    (acc_q[0] ? {1'b0, mag_a_q} : {(width + 1){1'b0}});
  assign mul_next = {mul_sum, acc_q[width-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}
  logic [width:0]   div_shift;
  logic [width:0]   div_diff;
  logic [dw-1:0]    div_next;

  assign div_shift = acc_q[dw-1:width-1];
  assign div_diff  = div_shift - {1'b0, mag_b_q};
  assign div_next  = div_diff[width]
                   ? {div_shift[width-1:0], acc_q[width-2:0], 1'b0}
                   : {div_diff[width-1:0],  acc_q[width-2:0], 1'b1};

  // Sign correction applied at commit
  logic [dw-1:0]    prod_fix;
  logic [width-1:0] quo_fix;
  logic [width-1:0] rem_fix;

  assign prod_fix = neg_lo_q ? (-acc_q) : acc_q;
  assign quo_fix  = neg_lo_q ? (-acc_q[width-1:0])  : acc_q[width-1:0];
  assign rem_fix  = neg_hi_q ? (-acc_q[dw-1:width]) : acc_q[dw-1:width];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= s_idle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      s_idle: begin
        if (start_op) begin
          is_div_d = (bus.op == op_div) || (bus.op == op_divu);
          mag_a_d  = abs_a;
          mag_b_d  = abs_b;
          a_d      = bus.A;
          // Product and quotient share the same sign rule; remainder follows the dividend
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          dz_d     = (bus.B == '0);
          // Upper half cleared; lower half holds the bits consumed one per cycle
          acc_d    = is_div_d ? {{width{1'b0}}, abs_a} : {{width{1'b0}}, abs_b};
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = s_calc;
        end else if (bus.op == op_mthi) begin
          hi_d = bus.A;
        end else if (bus.op == op_mtlo) begin
          lo_d = bus.A;
        end
      end

      s_calc: begin
        if (bus.cancel) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = s_idle;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == cnt_last) begin
            cnt_d   = '0;
            state_d = s_commit;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end
      end

      s_commit: begin
        busy_d  = 1'b0;
        state_d = s_idle;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[dw-1:width];
            lo_d = prod_fix[width-1:0];
          end else if (dz_q) begin
            // Divide by zero: all-ones quotient, dividend passed through as remainder
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = s_idle;
      end
    endcase
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv (width=32): reset, mul/div results, boundary
// divides, busy-time command masking, cancel and back-to-back issue.
module tb_hilo_muldiv;

  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] MULTU = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] DIVU  = 3'b100;
  localparam logic [2:0] MTHI  = 3'b101;
  localparam logic [2:0] MTLO  = 3'b110;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  hilo_muldiv_if #(.width(32)) bus ();

  hilo_muldiv #(.width(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a command at the current negedge, scramble operands afterwards and
  // wait (bounded) for busy to fall; returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int cycles);
    bus.op = o;
    bus.A  = a;
    bus.B  = b;
    @(negedge clk);
    bus.op = NONE;
    bus.A  = 32'hDEADBEEF;
    bus.B  = 32'h0BADF00D;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    #3;
    checks++; if (bus.hi !== 32'h0)  begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0)  begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.op = MTHI; bus.A = 32'h1111;
    @(negedge clk);
    bus.op = MTLO; bus.A = 32'h2222;
    @(negedge clk);
    bus.op = NONE;
    checks++; if (bus.hi !== 32'h1111) begin errors++; $display("FAIL mthi: got %h want 00001111", bus.hi); end
    checks++; if (bus.lo !== 32'h2222) begin errors++; $display("FAIL mtlo: got %h want 00002222", bus.lo); end
    // Asynchronous reset in the middle of an iteration
    bus.op = MULT; bus.A = 32'd7; bus.B = 32'd9;
    @(negedge clk);
    bus.op = NONE;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.hi !== 32'h0)  begin errors++; $display("FAIL midreset_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0)  begin errors++; $display("FAIL midreset_lo: got %h want 0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL postreset_idle: busy %b want 0", bus.busy); end
    run_op(MULT, 32'd7, 32'd9, cyc);
    checks++; if (bus.lo !== 32'd63) begin errors++; $display("FAIL mult7x9_lo: got %h want 0000003f", bus.lo); end
    checks++; if (bus.hi !== 32'd0)  begin errors++; $display("FAIL mult7x9_hi: got %h want 0", bus.hi); end
  endtask

  task automatic test_mult();
    int cyc;
    run_op(MULT, 32'hFFFFFFFD, 32'd5, cyc);
    checks++; if (cyc !== 33)              begin errors++; $display("FAIL mult_latency: got %0d want 33", cyc); end
    checks++; if (bus.done !== 1'b1)       begin errors++; $display("FAIL mult_done: got %b want 1", bus.done); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", bus.lo); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0)       begin errors++; $display("FAIL done_pulse: got %b want 0", bus.done); end
    run_op(MULTU, 32'hFFFFFFFD, 32'd5, cyc);
    checks++; if (bus.hi !== 32'h00000004) begin errors++; $display("FAIL multu_hi: got %h want 00000004", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL multu_lo: got %h want fffffff1", bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_div();
    int cyc;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, cyc);
    checks++; if (cyc !== 33)              begin errors++; $display("FAIL div_latency: got %0d want 33", cyc); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", bus.hi); end
    run_op(DIV, 32'd7, 32'hFFFFFFFE, cyc);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo: got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("FAIL div_negb_hi: got %h want 00000001", bus.hi); end
    run_op(DIVU, 32'd100, 32'd7, cyc);
    checks++; if (bus.lo !== 32'd14)       begin errors++; $display("FAIL divu_lo: got %h want 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'd2)        begin errors++; $display("FAIL divu_hi: got %h want 00000002", bus.hi); end
    @(negedge clk);
  endtask

  task automatic test_div_overflow();
    int cyc;
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0)        begin errors++; $display("FAIL divovf_hi: got %h want 0", bus.hi); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int cyc;
    run_op(DIVU, 32'h12345678, 32'h0, cyc);
    checks++; if (cyc !== 33)              begin errors++; $display("FAIL divz_latency: got %0d want 33", cyc); end
    checks++; if (bus.done !== 1'b1)       begin errors++; $display("FAIL divz_done: got %b want 1", bus.done); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divuz_lo: got %h want ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL divuz_hi: got %h want 12345678", bus.hi); end
    run_op(DIV, 32'hFFFFFFFB, 32'h0, cyc);
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFB) begin errors++; $display("FAIL divz_hi: got %h want fffffffb", bus.hi); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    bus.op = MTHI; bus.A = 32'h77;
    @(negedge clk);
    bus.op = MULT; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    bus.op = MTHI; bus.A = 32'hAA; bus.B = 32'h5555;
    @(negedge clk);
    bus.op = NONE;
    repeat (5) @(negedge clk);
    checks++; if (bus.hi !== 32'h77)  begin errors++; $display("FAIL busy_mthi_hold: got %h want 00000077", bus.hi); end
    checks++; if (bus.busy !== 1'b1)  begin errors++; $display("FAIL busy_mid: got %b want 1", bus.busy); end
    cyc = 0;
    while (bus.busy && cyc < 100) begin cyc++; @(negedge clk); end
    checks++; if (bus.done !== 1'b1)  begin errors++; $display("FAIL busy_done: got %b want 1", bus.done); end
    checks++; if (bus.lo !== 32'd12)  begin errors++; $display("FAIL busy_res_lo: got %h want 0000000c", bus.lo); end
    checks++; if (bus.hi !== 32'd0)   begin errors++; $display("FAIL busy_res_hi: got %h want 0", bus.hi); end
    @(negedge clk);
  endtask

  task automatic test_cancel();
    bit seen_done;
    bus.op = MTHI; bus.A = 32'h5A5A;
    @(negedge clk);
    bus.op = MTLO; bus.A = 32'hA5A5;
    @(negedge clk);
    // Cancel during CALC
    bus.op = DIVU; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.op = NONE;
    repeat (5) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0)   begin errors++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL cancel_done: got %b want 0", bus.done); end
    checks++; if (bus.hi !== 32'h5A5A) begin errors++; $display("FAIL cancel_hi: got %h want 00005a5a", bus.hi); end
    checks++; if (bus.lo !== 32'hA5A5) begin errors++; $display("FAIL cancel_lo: got %h want 0000a5a5", bus.lo); end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen_done !== 1'b0)  begin errors++; $display("FAIL cancel_quiet: got %b want 0", seen_done); end
    // Cancel in the commit cycle beats the commit
    bus.op = MULTU; bus.A = 32'd6; bus.B = 32'd7;
    @(negedge clk);
    bus.op = NONE;
    repeat (32) @(negedge clk);
    checks++; if (bus.busy !== 1'b1)   begin errors++; $display("FAIL commit_busy: got %b want 1", bus.busy); end
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL commit_cancel: busy %b done %b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.hi !== 32'h5A5A || bus.lo !== 32'hA5A5)
      begin errors++; $display("FAIL commit_cancel_hilo: got %h %h want 00005a5a 0000a5a5", bus.hi, bus.lo); end
    // Cancel in IDLE does not block a same-cycle command
    bus.cancel = 1'b1; bus.op = MTLO; bus.A = 32'h33;
    @(negedge clk);
    bus.cancel = 1'b0; bus.op = NONE;
    checks++; if (bus.lo !== 32'h33)   begin errors++; $display("FAIL idle_cancel_mtlo: got %h want 00000033", bus.lo); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(MULTU, 32'd6, 32'd7, cyc);
    checks++; if (bus.done !== 1'b1 || bus.lo !== 32'd42)
      begin errors++; $display("FAIL b2b_mul: done %b lo %h want 1 0000002a", bus.done, bus.lo); end
    bus.op = MTLO; bus.A = 32'h55;
    @(negedge clk);
    bus.op = NONE;
    checks++; if (bus.lo !== 32'h55)  begin errors++; $display("FAIL b2b_mtlo: got %h want 00000055", bus.lo); end
    checks++; if (bus.hi !== 32'h0)   begin errors++; $display("FAIL b2b_hi: got %h want 0", bus.hi); end
    run_op(DIVU, 32'd100, 32'd7, cyc);
    checks++; if (bus.done !== 1'b1 || bus.lo !== 32'd14 || bus.hi !== 32'd2)
      begin errors++; $display("FAIL b2b_div: done %b hi %h lo %h want 1 2 e", bus.done, bus.hi, bus.lo); end
    run_op(MULTU, 32'd2, 32'd3, cyc);
    checks++; if (cyc !== 33)         begin errors++; $display("FAIL b2b_nobubble: latency %0d want 33", cyc); end
    checks++; if (bus.lo !== 32'd6)   begin errors++; $display("FAIL b2b_mul2: got %h want 00000006", bus.lo); end
    @(negedge clk);
  endtask

  initial begin
    bus.op     = NONE;
    bus.A      = 32'h0;
    bus.B      = 32'h0;
    bus.cancel = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_overflow();
    test_div_zero();
    test_busy_ignore();
    test_cancel();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
